aven_avg_sa: RTL and testbench

- Parametrised successor to the fixed 8-sample averager.
- Computes a sliding-window moving average over 2^LOG2_WIN samples, independently for NCH sample channels.
- Exposes control, status and per-channel averages as a CyberBus-M slave on bus1.
- Also drives registered per-channel averages directly to downstream logic, such as the sorter.

---
 rtl/aven_avg_sa.sv | 198 +++++++++++++++++++
 tb/tb_aven_avg_sa.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/aven_avg_sa.sv
// rtl/aven_avg_sa.sv - per-channel sliding-window moving average with CyberBus-M register slave
`timescale 1ns/1ps
module aven_avg_sa #(
  parameter int DW       = 8,
  parameter int LOG2_WIN = 3,
  parameter int NCH      = 4
) (
  input  logic              bus1_HCLK,
  input  logic              bus1_HRESETn,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH*DW-1:0] avg_out,
  output logic [NCH-1:0]    avg_valid,
  input  logic              aven_SA_bus1_CBM_read_req,
  input  logic              aven_SA_bus1_CBM_write_req,
  input  logic [31:0]       aven_SA_bus1_CBM_addr,
  input  logic [2:0]        aven_SA_bus1_CBM_size,
  input  logic [31:0]       aven_SA_bus1_CBM_write_data,
  output logic [31:0]       aven_SA_bus1_CBM_read_data,
  output logic              aven_SA_bus1_CBM_busy,
  output logic              aven_SA_bus1_CBM_error,
  output logic              aven_SA_bus1_CBM_retry,
  output logic              aven_SA_bus1_CBM_split
);

  localparam int WIN = 1 << LOG2_WIN;
  localparam int SW  = DW + LOG2_WIN;
  localparam logic [LOG2_WIN:0]   WIN_C  = (LOG2_WIN+1)'(WIN);
  localparam logic [LOG2_WIN-1:0] LAST_I = LOG2_WIN'(WIN - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [LOG2_WIN-1:0] idx_q, idx_d;
  logic [DW-1:0]       ring_q [NCH][WIN];
  logic [DW-1:0]       ring_d [NCH][WIN];
  logic [LOG2_WIN-1:0] wp_q [NCH];
  logic [LOG2_WIN-1:0] wp_d [NCH];
  logic [SW-1:0]       sum_q [NCH];
  logic [SW-1:0]       sum_d [NCH];
  logic [LOG2_WIN:0]   cnt_q [NCH];
  logic [LOG2_WIN:0]   cnt_d [NCH];
  logic [DW-1:0]       avg_q [NCH];
  logic [DW-1:0]       avg_d [NCH];
  logic [NCH-1:0]      avg_valid_q, avg_valid_d;
  logic [NCH-1:0]      en_q, en_d;
  logic [NCH-1:0]      drop_q, drop_d;
  logic [NCH-1:0]      drop_set, w1c, full;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [3:0]  off, avg_idx;
  logic        busy, req, is_wr, is_ctrl, is_stat, is_avg, bad;
  logic [31:0] rd_val;
  logic        unused_ok;

  assign off     = aven_SA_bus1_CBM_addr[5:2];
  assign busy    = (state_q == CLEAR);
  assign req     = (aven_SA_bus1_CBM_read_req | aven_SA_bus1_CBM_write_req) & ~busy;
  assign is_wr   = aven_SA_bus1_CBM_write_req;
  assign is_ctrl = (off == 4'd0);
  assign is_stat = (off == 4'd1);
  assign avg_idx = off - 4'd4;
  assign is_avg  = (off >= 4'd4) && (32'(avg_idx) < NCH);
  assign bad     = (aven_SA_bus1_CBM_size != 3'b010) || !(is_ctrl || is_stat || is_avg)
                   || (is_wr && is_avg);

  assign unused_ok = ^{aven_SA_bus1_CBM_addr[31:6], aven_SA_bus1_CBM_addr[1:0],
                       aven_SA_bus1_CBM_write_data};

  always_comb begin
    for (int c = 0; c < NCH; c++) full[c] = (cnt_q[c] == WIN_C);
  end

  // AVG reads come from the registered sum, so a same-cycle update is not yet visible
  always_comb begin
    rd_val = '0;
    if (is_ctrl) begin
      rd_val[NCH-1:0] = en_q;
    end else if (is_stat) begin
      rd_val[NCH-1:0]  = full;
      rd_val[16 +: NCH] = drop_q;
    end else if (is_avg) begin
      for (int c = 0; c < NCH; c++) begin
        if (avg_idx == 4'(c)) rd_val[DW-1:0] = sum_q[c][SW-1 -: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    en_d        = en_q;
    avg_valid_d = '0;
    rdata_d     = '0;
    err_d       = 1'b0;
    drop_set    = '0;
    w1c         = '0;
    ring_d      = ring_q;
    wp_d        = wp_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;

    for (int c = 0; c < NCH; c++) begin
      if (in_valid[c] && en_q[c]) begin
        if (state_q == IDLE) begin
          sum_d[c] = sum_q[c] + SW'(in_data[c*DW +: DW]) - SW'(ring_q[c][wp_q[c]]);
          ring_d[c][wp_q[c]] = in_data[c*DW +: DW];
          wp_d[c] = wp_q[c] + 1'b1;
          if (cnt_q[c] != WIN_C) cnt_d[c] = cnt_q[c] + 1'b1;
          avg_d[c]       = sum_d[c][SW-1 -: DW];
          avg_valid_d[c] = (cnt_d[c] == WIN_C);
        end else begin
          drop_set[c] = 1'b1;
        end
      end
    end

    if (state_q == CLEAR) begin
      for (int c = 0; c < NCH; c++) ring_d[c][idx_q] = '0;
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_I) state_d = IDLE;
    end

    if (req) begin
      if (bad) begin
        err_d = 1'b1;
      end else if (is_wr) begin
        if (is_ctrl) begin
          en_d = aven_SA_bus1_CBM_write_data[NCH-1:0];
          // Clear entry wins over any sample landing on the same edge
          if (aven_SA_bus1_CBM_write_data[16]) begin
            state_d     = CLEAR;
            idx_d       = '0;
            avg_valid_d = '0;
            for (int c = 0; c < NCH; c++) begin
              sum_d[c] = '0;
              cnt_d[c] = '0;
              wp_d[c]  = '0;
              avg_d[c] = '0;
            end
          end
        end else if (is_stat) begin
          w1c = aven_SA_bus1_CBM_write_data[16 +: NCH];
        end
      end else begin
        rdata_d = rd_val;
      end
    end

    drop_d = (drop_q & ~w1c) | drop_set;
  end

  always_ff @(posedge bus1_HCLK or negedge bus1_HRESETn) begin
    if (!bus1_HRESETn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      en_q        <= '0;
      drop_q      <= '0;
      avg_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        wp_q[c]  <= '0;
        sum_q[c] <= '0;
        cnt_q[c] <= '0;
        avg_q[c] <= '0;
        for (int w = 0; w < WIN; w++) ring_q[c][w] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      drop_q      <= drop_d;
      avg_valid_q <= avg_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      wp_q        <= wp_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      ring_q      <= ring_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign avg_out[g*DW +: DW] = avg_q[g];
  end

  assign avg_valid                  = avg_valid_q;
  assign aven_SA_bus1_CBM_read_data = rdata_q;
  assign aven_SA_bus1_CBM_busy      = busy;
  assign aven_SA_bus1_CBM_error     = err_q;
  assign aven_SA_bus1_CBM_retry     = 1'b0;
  assign aven_SA_bus1_CBM_split     = 1'b0;

endmodule

// File: tb/tb_aven_avg_sa.sv
// tb/tb_aven_avg_sa.sv - self-checking bench for aven_avg_sa (DW=8, LOG2_WIN=3, NCH=4)
`timescale 1ns/1ps
module tb_aven_avg_sa;

  localparam int DW = 8;
  localparam int LOG2_WIN = 3;
  localparam int NCH = 4;

  logic              clk, rst_n;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] avg_out;
  logic [NCH-1:0]    avg_valid;
  logic              read_req, write_req;
  logic [31:0]       addr, wdata, read_data;
  logic [2:0]        size;
  logic              busy, error, retry, split;

  aven_avg_sa #(.DW(DW), .LOG2_WIN(LOG2_WIN), .NCH(NCH)) dut (
    .bus1_HCLK                   (clk),
    .bus1_HRESETn                (rst_n),
    .in_data                     (in_data),
    .in_valid                    (in_valid),
    .avg_out                     (avg_out),
    .avg_valid                   (avg_valid),
    .aven_SA_bus1_CBM_read_req   (read_req),
    .aven_SA_bus1_CBM_write_req  (write_req),
    .aven_SA_bus1_CBM_addr       (addr),
    .aven_SA_bus1_CBM_size       (size),
    .aven_SA_bus1_CBM_write_data (wdata),
    .aven_SA_bus1_CBM_read_data  (read_data),
    .aven_SA_bus1_CBM_busy       (busy),
    .aven_SA_bus1_CBM_error      (error),
    .aven_SA_bus1_CBM_retry      (retry),
    .aven_SA_bus1_CBM_split      (split)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]    v;
    logic [NCH*DW-1:0] d;
    logic [NCH*DW-1:0] exp_avg;
    logic [NCH-1:0]    exp_vld;
  } svec_t;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
  } bvec_t;

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } bexp_t;

  svec_t sv [10];
  bvec_t bv [7];
  svec_t sq [$];
  bexp_t bq [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus_chk(input string nm, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_er);
    bexp_t e;
    bq.push_back('{rd: exp_rd, er: exp_er});
    @(negedge clk);
    read_req = !wr; write_req = wr; addr = a; size = sz; wdata = wd;
    @(posedge clk); #1;
    read_req = 1'b0; write_req = 1'b0;
    e = bq.pop_front();
    chk({nm, " rdata"}, read_data, e.rd);
    chk({nm, " error"}, 32'(error), 32'(e.er));
  endtask

  task automatic apply_row(input int i, input bit ch0_only);
    svec_t e;
    e = sv[i];
    if (ch0_only) begin
      e.exp_avg[NCH*DW-1:DW] = '0;
      e.exp_vld = e.exp_vld & 4'b0001;
    end
    sq.push_back(e);
    @(negedge clk);
    in_valid = sv[i].v; in_data = sv[i].d;
    @(posedge clk); #1;
    in_valid = '0;
    e = sq.pop_front();
    chk($sformatf("avg_out row%0d", i), avg_out, e.exp_avg);
    chk($sformatf("avg_valid row%0d", i), 32'(avg_valid), 32'(e.exp_vld));
  endtask

  initial begin
    int d0  [10] = '{8, 16, 24, 32, 40, 48, 56, 64, 200, 0};
    int e0  [10] = '{1, 3, 6, 10, 15, 21, 28, 36, 60, 58};
    int e13 [10] = '{31, 63, 95, 127, 159, 191, 223, 255, 255, 255};
    int cnt;
    logic saw_err;

    for (int i = 0; i < 10; i++) begin
      sv[i].v       = (i < 8) ? 4'b1111 : 4'b0001;
      sv[i].d       = {8'd255, 8'd77, 8'd255, 8'(d0[i])};
      sv[i].exp_avg = {8'(e13[i]), 8'd0, 8'(e13[i]), 8'(e0[i])};
      sv[i].exp_vld = (i == 7) ? 4'b1011 : (i >= 8) ? 4'b0001 : 4'b0000;
    end
    bv[0] = '{1'b0, 32'h20, 3'b010, 32'h0,  32'h0, 1'b1};
    bv[1] = '{1'b1, 32'h10, 3'b010, 32'h55, 32'h0, 1'b1};
    bv[2] = '{1'b0, 32'h00, 3'b000, 32'h0,  32'h0, 1'b1};
    bv[3] = '{1'b1, 32'h00, 3'b000, 32'h0,  32'h0, 1'b1};
    bv[4] = '{1'b0, 32'h00, 3'b010, 32'h0,  32'hF, 1'b0};
    bv[5] = '{1'b0, 32'h08, 3'b010, 32'h0,  32'h0, 1'b1};
    bv[6] = '{1'b0, 32'h10, 3'b010, 32'h0,  32'h0, 1'b0};

    rst_n = 1'b0; in_valid = '0; in_data = '0;
    read_req = 1'b0; write_req = 1'b0; addr = '0; size = 3'b010; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset avg_out", avg_out, 32'h0);
    chk("reset busy/err/vld", {26'd0, busy, error, avg_valid}, 32'h0);
    chk("reset read_data", read_data, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // window fill, slide/wrap, channel independence
    bus_chk("ctrl en", 1'b1, 32'h0, 3'b010, 32'hB, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) apply_row(i, 1'b0);
    @(posedge clk); #1;
    chk("valid single cycle", 32'(avg_valid), 32'h0);
    chk("avg held", 32'(avg_out[7:0]), 32'd58);

    // AVG read coinciding with an update returns the old value
    @(negedge clk);
    read_req = 1'b1; addr = 32'h10; size = 3'b010;
    in_valid = 4'b0001; in_data = 32'd80;
    @(posedge clk); #1;
    read_req = 1'b0; in_valid = '0;
    chk("coincident read old", read_data, 32'd58);
    chk("coincident avg new", 32'(avg_out[7:0]), 32'd65);
    chk("coincident vld", 32'(avg_valid), 32'h1);

    bus_chk("status full", 1'b0, 32'h04, 3'b010, 32'h0, 32'h0000000B, 1'b0);
    bus_chk("avg0", 1'b0, 32'h10, 3'b010, 32'h0, 32'd65, 1'b0);
    bus_chk("avg1", 1'b0, 32'h14, 3'b010, 32'h0, 32'd255, 1'b0);
    bus_chk("avg2", 1'b0, 32'h18, 3'b010, 32'h0, 32'd0, 1'b0);
    bus_chk("avg3", 1'b0, 32'h1C, 3'b010, 32'h0, 32'd255, 1'b0);
    bus_chk("ctrl rd", 1'b0, 32'h00, 3'b010, 32'h0, 32'hB, 1'b0);

    // clear sweep
    bus_chk("clr wr", 1'b1, 32'h0, 3'b010, 32'h0001000F, 32'h0, 1'b0);
    chk("avg zero on clr", avg_out, 32'h0);
    cnt = 0; saw_err = 1'b0;
    while (busy && cnt < 20) begin
      cnt++;
      in_valid  = (cnt == 2) ? 4'b0001 : 4'b0000;
      in_data   = 32'd99;
      write_req = (cnt == 4);
      addr = 32'h0; size = 3'b010; wdata = 32'h0;
      @(posedge clk); #1;
      saw_err = saw_err | error;
    end
    in_valid = '0; write_req = 1'b0;
    chk("busy cycles", 32'(cnt), 32'd8);
    chk("no resp in busy", 32'(saw_err), 32'h0);
    bus_chk("status drop", 1'b0, 32'h04, 3'b010, 32'h0, 32'h00010000, 1'b0);
    for (int c = 0; c < NCH; c++)
      bus_chk($sformatf("avg%0d clr", c), 1'b0, 32'h10 + 32'(4*c), 3'b010, 32'h0, 32'h0, 1'b0);
    bus_chk("ctrl after clr", 1'b0, 32'h00, 3'b010, 32'h0, 32'hF, 1'b0);
    bus_chk("w1c", 1'b1, 32'h04, 3'b010, 32'h00010000, 32'h0, 1'b0);
    bus_chk("status w1c", 1'b0, 32'h04, 3'b010, 32'h0, 32'h0, 1'b0);

    // bus errors
    for (int i = 0; i < 7; i++) begin
      bus_chk($sformatf("bus row%0d", i), bv[i].wr, bv[i].a, bv[i].sz, bv[i].wd,
              bv[i].exp_rd, bv[i].exp_er);
      @(posedge clk); #1;
      chk($sformatf("bus row%0d err drop", i), 32'(error), 32'h0);
    end

    // reset in CLEAR cycle 3
    bus_chk("clr2 wr", 1'b1, 32'h0, 3'b010, 32'h0001000F, 32'h0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    chk("busy before rst", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("busy in rst", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    bus_chk("ctrl after rst", 1'b0, 32'h00, 3'b010, 32'h0, 32'h0, 1'b0);
    bus_chk("ctrl en0", 1'b1, 32'h0, 3'b010, 32'h1, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) apply_row(i, 1'b1);
    bus_chk("status ch0 full", 1'b0, 32'h04, 3'b010, 32'h0, 32'h1, 1'b0);
    bus_chk("avg0 refill", 1'b0, 32'h10, 3'b010, 32'h0, 32'd36, 1'b0);
    chk("retry/split", {30'd0, retry, split}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
